// File: rtl/lc3b_mem_responder.sv
// Word-addressed 16-bit memory slave answering LC-3b style read/write
// requests after a fixed LATENCY, with byte-masked writes and abort support.
module lc3b_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LATENCY    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mem_address,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_resp,
  output logic        protocol_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic [15:0] storage [0:(1 << ADDR_WIDTH) - 1];

  logic [1:0]            state;
  logic [1:0]            state_next;
  logic [3:0]            count;
  logic [3:0]            count_next;
  logic                  accept;
  logic                  enter_resp;
  logic                  req;

  logic [ADDR_WIDTH-1:0] in_addr;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic                  lat_write;
  logic [1:0]            lat_be;
  logic [15:0]           lat_wdata;

  logic [ADDR_WIDTH-1:0] eff_addr;
  logic                  eff_write;
  logic [1:0]            eff_be;
  logic [15:0]           eff_wdata;

  assign req     = mem_read | mem_write;
  assign in_addr = mem_address[ADDR_WIDTH:1];

  // Address bits outside the word index are intentionally ignored.
  logic unused_lsb;
  assign unused_lsb = mem_address[0];
  if (ADDR_WIDTH < 15) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^mem_address[15:ADDR_WIDTH+1];
  end

  // With LATENCY=1 the RESP entry edge is also the accept edge, so the
  // live inputs must be used instead of the not-yet-loaded latches.
  always_comb begin
    if (state == IDLE) begin
      eff_addr  = in_addr;
      eff_write = mem_write;
      eff_be    = mem_byte_enable;
      eff_wdata = mem_wdata;
    end else begin
      eff_addr  = lat_addr;
      eff_write = lat_write;
      eff_be    = lat_be;
      eff_wdata = lat_wdata;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = BUSY;
            count_next = LAT_M1;
          end
        end
      end
      BUSY: begin
        if (!req) begin
          state_next = IDLE;
          count_next = '0;
        end else if (count == 4'd1) begin
          state_next = RESP;
          enter_resp = 1'b1;
          count_next = '0;
        end else begin
          count_next = count - 4'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  // Storage lives in the reset block but is never touched by reset, so a
  // reset at any point cancels the pending write and keeps old contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      mem_resp     <= 1'b0;
      mem_rdata    <= '0;
      protocol_err <= 1'b0;
      lat_addr     <= '0;
      lat_write    <= 1'b0;
      lat_be       <= '0;
      lat_wdata    <= '0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      mem_resp <= enter_resp;

      if (accept) begin
        lat_addr  <= in_addr;
        lat_write <= mem_write;
        lat_be    <= mem_byte_enable;
        lat_wdata <= mem_wdata;
      end

      if ((state == IDLE) && mem_read && mem_write) begin
        protocol_err <= 1'b1;
      end

      if (enter_resp) begin
        if (eff_write) begin
          if (eff_be[0]) storage[eff_addr][7:0]  <= eff_wdata[7:0];
          if (eff_be[1]) storage[eff_addr][15:8] <= eff_wdata[15:8];
        end else begin
          mem_rdata <= storage[eff_addr];
        end
      end
    end
  end

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Directed bench: one responder at LATENCY=3 and one at LATENCY=1.
module tb_lc3b_mem_responder;

  logic        clk = 1'b0;
  logic        reset;

  logic [15:0] a_addr, a_wdata, a_rdata;
  logic        a_read, a_write, a_resp, a_perr;
  logic [1:0]  a_be;

  logic [15:0] b_addr, b_wdata, b_rdata;
  logic        b_read, b_write, b_resp, b_perr;
  logic [1:0]  b_be;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lc3b_mem_responder #(.ADDR_WIDTH(8), .LATENCY(3)) dut (
    .clk(clk), .reset(reset), .mem_address(a_addr), .mem_read(a_read),
    .mem_write(a_write), .mem_byte_enable(a_be), .mem_wdata(a_wdata),
    .mem_rdata(a_rdata), .mem_resp(a_resp), .protocol_err(a_perr)
  );

  lc3b_mem_responder #(.ADDR_WIDTH(8), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .mem_address(b_addr), .mem_read(b_read),
    .mem_write(b_write), .mem_byte_enable(b_be), .mem_wdata(b_wdata),
    .mem_rdata(b_rdata), .mem_resp(b_resp), .protocol_err(b_perr)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; holds the request until mem_resp, then drops it.
  task automatic xact(input logic rd, input logic wr, input logic [15:0] addr,
                      input logic [1:0] be, input logic [15:0] wd,
                      output int lat, output logic [15:0] rdv);
    a_read = rd; a_write = wr; a_addr = addr; a_be = be; a_wdata = wd;
    lat = 0;
    rdv = '0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (a_resp) break;
    end
    rdv = a_rdata;
    a_read = 1'b0; a_write = 1'b0;
    @(posedge clk); #1;
    check("resp_width", 16'(a_resp), 16'h0);
  endtask

  int          lat;
  logic [15:0] rdv;
  int          seen;

  initial begin
    reset = 1'b1;
    a_addr = '0; a_read = 1'b0; a_write = 1'b0; a_be = '0; a_wdata = '0;
    b_addr = '0; b_read = 1'b0; b_write = 1'b0; b_be = '0; b_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp", 16'(a_resp), 16'h0);
    check("rst_rdata", a_rdata, 16'h0000);
    check("rst_perr", 16'(a_perr), 16'h0);
    check("rst_resp_l1", 16'(b_resp), 16'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    xact(1'b0, 1'b1, 16'h0010, 2'b11, 16'hBEEF, lat, rdv);
    check("wr_latency", 16'(lat), 16'd3);
    xact(1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000, lat, rdv);
    check("rd_latency", 16'(lat), 16'd3);
    check("rd_full", rdv, 16'hBEEF);

    xact(1'b0, 1'b1, 16'h0010, 2'b01, 16'h1234, lat, rdv);
    xact(1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000, lat, rdv);
    check("rd_be01", rdv, 16'hBE34);
    xact(1'b0, 1'b1, 16'h0010, 2'b10, 16'h5600, lat, rdv);
    xact(1'b1, 1'b0, 16'h0010, 2'b11, 16'h0000, lat, rdv);
    check("rd_be10", rdv, 16'h5634);

    xact(1'b0, 1'b1, 16'h0211, 2'b11, 16'hA5A5, lat, rdv);
    xact(1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000, lat, rdv);
    check("rd_alias", rdv, 16'hA5A5);

    xact(1'b0, 1'b1, 16'h0010, 2'b00, 16'hFFFF, lat, rdv);
    check("be00_latency", 16'(lat), 16'd3);
    check("rdata_hold", a_rdata, 16'hA5A5);
    xact(1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000, lat, rdv);
    check("rd_be00", rdv, 16'hA5A5);

    // abort a write after one BUSY cycle
    a_write = 1'b1; a_addr = 16'h0010; a_be = 2'b11; a_wdata = 16'h0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_write = 1'b0;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      seen = seen | int'(a_resp);
    end
    check("abort_noresp", 16'(seen), 16'h0);
    xact(1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000, lat, rdv);
    check("abort_nowrite", rdv, 16'hA5A5);

    // inputs changed after acceptance must not matter
    a_write = 1'b1; a_addr = 16'h0010; a_be = 2'b11; a_wdata = 16'h1111;
    @(posedge clk); #1;
    a_addr = 16'h0030; a_be = 2'b00; a_wdata = 16'h9999;
    lat = 1;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (a_resp) break;
    end
    a_write = 1'b0;
    check("latch_latency", 16'(lat), 16'd3);
    @(posedge clk); #1;
    xact(1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000, lat, rdv);
    check("latch_data", rdv, 16'h1111);

    // reset during a read
    a_read = 1'b1; a_addr = 16'h0010;
    @(posedge clk); #1;
    reset = 1'b1; a_read = 1'b0;
    #1;
    check("rstmid_rdata", a_rdata, 16'h0000);
    check("rstmid_resp", 16'(a_resp), 16'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    // reset during a write
    a_write = 1'b1; a_addr = 16'h0010; a_be = 2'b11; a_wdata = 16'h2222;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; a_write = 1'b0;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      seen = seen | int'(a_resp);
    end
    reset = 1'b0;
    check("rstmid_noresp", 16'(seen), 16'h0);
    @(posedge clk); #1;
    xact(1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000, lat, rdv);
    check("rst_keeps_mem", rdv, 16'h1111);

    // simultaneous read+write
    xact(1'b1, 1'b1, 16'h0020, 2'b11, 16'hCAFE, lat, rdv);
    check("perr_set", 16'(a_perr), 16'h1);
    xact(1'b1, 1'b0, 16'h0020, 2'b00, 16'h0000, lat, rdv);
    check("perr_write", rdv, 16'hCAFE);
    check("perr_sticky", 16'(a_perr), 16'h1);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    @(posedge clk); #1;
    check("perr_clear", 16'(a_perr), 16'h0);

    // LATENCY=1 instance
    b_write = 1'b1; b_addr = 16'h0004; b_be = 2'b11; b_wdata = 16'h1357;
    @(posedge clk); #1;
    check("l1_wr_resp", 16'(b_resp), 16'h1);
    b_write = 1'b0;
    @(posedge clk); #1;
    check("l1_wr_width", 16'(b_resp), 16'h0);
    b_read = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("l1_b2b_resp", 16'(b_resp), (i % 2 == 0) ? 16'h1 : 16'h0);
      seen = seen + int'(b_resp);
    end
    b_read = 1'b0;
    check("l1_b2b_pulses", 16'(seen), 16'd3);
    check("l1_rdata", b_rdata, 16'h1357);
    check("l1_perr", 16'(b_perr), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lc3b_mem_responder.md
LC3B_MEM_RESPONDER -- requirements
Module: lc3b_mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, giving the number of word-address bits; storage is 2^ADDR_WIDTH 16-bit words.
REQ-002 The block SHALL have parameter LATENCY, default 3, giving the number of cycles from request acceptance to mem_resp; legal range is 1..15.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: reset  input  1  asynchronous active-high reset.
REQ-006 Port: mem_address  input  16  byte address; bit 0 is ignored, bits [ADDR_WIDTH:1] select the word, and higher bits are ignored.
REQ-007 Port: mem_read  input  1  read request, held by the initiator until mem_resp.
REQ-008 Port: mem_write  input  1  write request, held by the initiator until mem_resp.
REQ-009 Port: mem_byte_enable  input  2  write mask; bit0 selects [7:0] and bit1 selects [15:8].
REQ-010 Port: mem_wdata  input  16  write data.
REQ-011 Port: mem_rdata  output  16  read data, registered.
REQ-012 Port: mem_resp  output  1  single-cycle completion pulse, registered.
REQ-013 Port: protocol_err  output  1  sticky violation flag, registered.

Function
REQ-014 The FSM SHALL have three states: IDLE, BUSY and RESP.
REQ-015 In IDLE, a rising edge with mem_read or mem_write high SHALL accept the request:
- latch word address, op, mem_byte_enable and mem_wdata;
- go to BUSY with the counter loaded to LATENCY-1, or go directly to RESP if LATENCY=1.
REQ-016 In BUSY, the counter SHALL decrement each cycle; on the edge where it equals 1, the FSM SHALL go to RESP.
REQ-017 mem_resp SHALL be high only in RESP, for exactly one cycle per accepted request; the state after RESP SHALL be IDLE.
REQ-018 For a request first sampled high at edge N, mem_resp SHALL be high in the cycle following edge N+LATENCY-1, so the initiator sees mem_resp LATENCY cycles after the request is sampled.
REQ-019 Read: mem_rdata SHALL be loaded with the latched word on the edge entering RESP, and SHALL be held until the next read's RESP entry.
REQ-020 Write: the storage word SHALL be updated on the edge entering RESP, only for enabled bytes; the other byte SHALL be unchanged.
REQ-021 A write with mem_byte_enable=2'b00 SHALL complete with mem_resp and SHALL change no storage.
REQ-022 Reads SHALL ignore mem_byte_enable and return the full word.
REQ-023 Input changes after acceptance SHALL be ignored; the latched values SHALL be used.
REQ-024 Abort: if both mem_read and mem_write are low during BUSY:
- return to IDLE on that edge;
- do not write storage, update mem_rdata or pulse mem_resp.
REQ-025 Simultaneous mem_read and mem_write sampled in IDLE SHALL:
- set protocol_err;
- be treated as a write.
REQ-026 A request still asserted in the cycle after RESP SHALL be accepted as a new request in IDLE.
REQ-027 Address wrap: word index SHALL be mem_address[ADDR_WIDTH:1]; addresses beyond storage size alias modulo 2^ADDR_WIDTH.

Reset
REQ-028 Reset SHALL set:
- state IDLE;
- counter 0;
- mem_resp 0;
- mem_rdata 16'h0000;
- protocol_err 0.
REQ-029 Reset asserted mid-request SHALL cancel the request with no storage write and no mem_resp.
REQ-030 Storage contents SHALL NOT be altered by reset.
REQ-031 protocol_err SHALL be cleared only by reset.

Verification
REQ-032 Full write then read, LATENCY=3: write addr 16'h0010, data 16'hBEEF, be=2'b11, then read 16'h0010 -> mem_resp 3 cycles after each request, one cycle wide; mem_rdata=16'hBEEF in the read RESP cycle.
REQ-033 Byte write: write 16'h0010 be=2'b01 data 16'h1234 over 16'hBEEF, then read -> mem_rdata 16'hBE34; be=2'b10 data 16'h5600 -> mem_rdata 16'h5634.
REQ-034 Alias and odd address: write 16'h0211 data 16'hA5A5 (ADDR_WIDTH=8), then read 16'h0010 -> mem_rdata 16'hA5A5.
REQ-035 Abort: drop mem_write after 1 BUSY cycle -> no mem_resp, storage unchanged on subsequent read; assert reset mid-read -> mem_resp stays 0, mem_rdata=16'h0000.
REQ-036 Violation and LATENCY=1: mem_read and mem_write together -> protocol_err=1 until reset, write performed; with LATENCY=1, mem_resp appears 1 cycle after request and back-to-back held requests each produce one pulse.
